// File: rtl/unidade_controle_multiciclo_pkg.sv
// Shared opcode map, state encoding and opcode classification for the multi-cycle control unit.
package uc_pkg;

    localparam logic [5:0] OP_ADD    = 6'b000000;
    localparam logic [5:0] OP_SUB    = 6'b000001;
    localparam logic [5:0] OP_AND    = 6'b000010;
    localparam logic [5:0] OP_OR     = 6'b000011;
    localparam logic [5:0] OP_XOR    = 6'b000100;
    localparam logic [5:0] OP_NOT    = 6'b000101;
    localparam logic [5:0] OP_SHR    = 6'b000110;
    localparam logic [5:0] OP_SHL    = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_SUBI   = 6'b001001;
    localparam logic [5:0] OP_BEQ    = 6'b001010;
    localparam logic [5:0] OP_BNE    = 6'b001011;
    localparam logic [5:0] OP_BLE    = 6'b001100;
    localparam logic [5:0] OP_BGR    = 6'b001101;
    localparam logic [5:0] OP_JUMP   = 6'b001110;
    localparam logic [5:0] OP_JUMPJR = 6'b001111;
    localparam logic [5:0] OP_JUMPJL = 6'b010000;
    localparam logic [5:0] OP_IN     = 6'b010001;
    localparam logic [5:0] OP_OUT    = 6'b010010;
    localparam logic [5:0] OP_LOAD   = 6'b010011;
    localparam logic [5:0] OP_STORE  = 6'b010100;
    localparam logic [5:0] OP_LOADIM = 6'b010101;
    localparam logic [5:0] OP_HLT    = 6'b111111;

    localparam logic [1:0] W_DATA_ALU = 2'b00;
    localparam logic [1:0] W_DATA_MEM = 2'b01;
    localparam logic [1:0] W_DATA_IO  = 2'b11;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXEC    = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        WAIT_IN = 3'd5,
        HALTED  = 3'd6
    } state_t;

    typedef struct packed {
        logic alu;
        logic imm;
        logic branch;
        logic load;
        logic store;
        logic inp;
        logic outp;
        logic jumpjl;
        logic jumpjr;
        logic hlt;
    } op_class_t;

    function automatic op_class_t decode_op(input logic [5:0] op);
        op_class_t c;
        c = '0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOT, OP_SHR, OP_SHL:   c.alu    = 1'b1;
            OP_ADDI, OP_SUBI, OP_LOADIM:      c.imm    = 1'b1;
            OP_BEQ, OP_BNE, OP_BLE, OP_BGR:   c.branch = 1'b1;
            OP_JUMP:                          c        = '0;
            OP_JUMPJR:                        c.jumpjr = 1'b1;
            OP_JUMPJL:                        c.jumpjl = 1'b1;
            OP_IN:                            c.inp    = 1'b1;
            OP_OUT:                           c.outp   = 1'b1;
            OP_LOAD:                          c.load   = 1'b1;
            OP_STORE:                         c.store  = 1'b1;
            OP_HLT:                           c.hlt    = 1'b1;
            default:                          c        = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/unidade_controle_multiciclo_botao_debounce.sv
// Button conditioner: two-flop synchroniser, stability counter and one-cycle pulse on an accepted rising level.
module botao_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic botao,
    output logic sync,
    output logic level,
    output logic rise
);

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1_r;
    logic       sync2_r;
    logic [7:0] cnt_r;

    assign sync = sync2_r;

    // Synchronise, then accept a new level only after it has held DEBOUNCE_CYCLES samples.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            cnt_r   <= 8'd0;
            level   <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync1_r <= botao;
            sync2_r <= sync1_r;
            if (sync2_r == level) begin
                cnt_r <= 8'd0;
                rise  <= 1'b0;
            end else if (cnt_r == DB_LAST) begin
                cnt_r <= 8'd0;
                level <= sync2_r;
                rise  <= sync2_r;
            end else begin
                cnt_r <= cnt_r + 8'd1;
                rise  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with registered datapath strobes.
// Optional instruction counter output enabled by defining INSTR_COUNT_EN.
module unidade_controle_multiciclo
    import uc_pkg::*;
#(
    parameter int OPCODE_W        = 6,
    parameter int MEM_LAT         = 1,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] Modo_Funcao_UC_Instrucao,
    input  logic                clock_botao,
    output logic                pc_write,
    output logic                ir_write,
    output logic                Seletor_Desvio_UC,
    output logic                we_UC,
    output logic                IO_UC,
    output logic                Reg_Write_UC,
    output logic                Seletor_ULA_UC,
    output logic                Seletor_regJr_UC,
    output logic                Reg_Write_Jr_UC,
    output logic                halt,
    output logic [1:0]          Seletor_W_Data_UC,
    output logic [OPCODE_W-1:0] Modo_Funcao_UC,
    output logic [2:0]          estado
`ifdef INSTR_COUNT_EN
    ,
    output logic [31:0]         instr_count
`endif
);

    localparam logic [3:0] MEM_LAST = 4'(MEM_LAT);

    state_t              state_r, next_state_s;
    logic [3:0]          mem_cnt_r, mem_cnt_next_s;
    logic [OPCODE_W-1:0] op_eff_s;
    op_class_t           cls_s;
    logic                btn_sync_s, btn_level_s, btn_rise_s;
    logic                armed_r;
    logic                n_pc, n_ir, n_desv, n_we, n_io, n_rw, n_ula, n_rjr, n_rjl, n_halt;
    logic [1:0]          n_wd;

    botao_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_botao (
        .clock (clock),
        .reset (reset),
        .botao (clock_botao),
        .sync  (btn_sync_s),
        .level (btn_level_s),
        .rise  (btn_rise_s)
    );

    // In DECODE the opcode comes straight from the IR; afterwards from the latched copy.
    assign op_eff_s = (state_r == DECODE) ? Modo_Funcao_UC_Instrucao : Modo_Funcao_UC;
    assign cls_s    = (op_eff_s == OPCODE_W'(op_eff_s[5:0])) ? decode_op(op_eff_s[5:0]) : '0;
    assign estado   = state_r;

    // Next-state and MEM wait counter.
    always_comb begin
        next_state_s   = state_r;
        mem_cnt_next_s = mem_cnt_r;
        case (state_r)
            FETCH:   next_state_s = DECODE;
            DECODE: begin
                if (cls_s.hlt)      next_state_s = HALTED;
                else if (cls_s.inp) next_state_s = WAIT_IN;
                else                next_state_s = EXEC;
            end
            EXEC: begin
                if (cls_s.load || cls_s.store) begin
                    next_state_s   = MEM;
                    mem_cnt_next_s = 4'd0;
                end else begin
                    next_state_s   = WB;
                end
            end
            MEM: begin
                if (mem_cnt_r == MEM_LAST) next_state_s   = WB;
                else                       mem_cnt_next_s = mem_cnt_r + 4'd1;
            end
            WB:      next_state_s = FETCH;
            WAIT_IN: begin
                if (btn_rise_s && armed_r) next_state_s = WB;
                else                       next_state_s = WAIT_IN;
            end
            HALTED:  next_state_s = HALTED;
            default: next_state_s = FETCH;
        endcase
    end

    // Output values for the state being entered; registered below.
    always_comb begin
        n_pc   = 1'b0;
        n_ir   = 1'b0;
        n_desv = 1'b0;
        n_we   = 1'b0;
        n_io   = 1'b0;
        n_rw   = 1'b0;
        n_ula  = 1'b0;
        n_rjr  = 1'b1;
        n_rjl  = 1'b0;
        n_halt = 1'b0;
        n_wd   = W_DATA_ALU;
        case (next_state_s)
            FETCH:   n_ir = 1'b1;
            EXEC: begin
                n_ula  = cls_s.imm;
                n_desv = cls_s.branch;
            end
            MEM:     n_we = cls_s.store && (mem_cnt_next_s == MEM_LAST);
            WB: begin
                n_pc  = 1'b1;
                n_rw  = cls_s.alu || cls_s.imm || cls_s.load || cls_s.inp;
                n_io  = cls_s.outp;
                n_rjl = cls_s.jumpjl;
                n_rjr = ~cls_s.jumpjr;
                if (cls_s.load)                    n_wd = W_DATA_MEM;
                else if (cls_s.inp || cls_s.outp)  n_wd = W_DATA_IO;
                else                               n_wd = W_DATA_ALU;
            end
            WAIT_IN: begin
                n_halt = 1'b1;
                n_io   = 1'b1;
            end
            HALTED:  n_halt = 1'b1;
            default: n_ir = 1'b0;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r           <= FETCH;
            mem_cnt_r         <= 4'd0;
            Modo_Funcao_UC    <= '0;
            pc_write          <= 1'b0;
            ir_write          <= 1'b0;
            Seletor_Desvio_UC <= 1'b0;
            we_UC             <= 1'b0;
            IO_UC             <= 1'b0;
            Reg_Write_UC      <= 1'b0;
            Seletor_ULA_UC    <= 1'b0;
            Seletor_regJr_UC  <= 1'b1;
            Reg_Write_Jr_UC   <= 1'b0;
            halt              <= 1'b0;
            Seletor_W_Data_UC <= W_DATA_ALU;
        end else begin
            state_r           <= next_state_s;
            mem_cnt_r         <= mem_cnt_next_s;
            Modo_Funcao_UC    <= op_eff_s;
            pc_write          <= n_pc;
            ir_write          <= n_ir;
            Seletor_Desvio_UC <= n_desv;
            we_UC             <= n_we;
            IO_UC             <= n_io;
            Reg_Write_UC      <= n_rw;
            Seletor_ULA_UC    <= n_ula;
            Seletor_regJr_UC  <= n_rjr;
            Reg_Write_Jr_UC   <= n_rjl;
            halt              <= n_halt;
            Seletor_W_Data_UC <= n_wd;
        end
    end

    // A button already high when WAIT_IN is entered must be released before a press counts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            armed_r <= 1'b0;
        end else if (state_r == DECODE && next_state_s == WAIT_IN) begin
            armed_r <= ~btn_sync_s;
        end else if (state_r == WAIT_IN && !btn_level_s && !btn_sync_s) begin
            armed_r <= 1'b1;
        end else begin
            armed_r <= armed_r;
        end
    end

`ifdef INSTR_COUNT_EN
    // Counts completed write-back cycles, wrapping naturally at 32 bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr_count <= 32'd0;
        end else if (state_r == WB) begin
            instr_count <= instr_count + 32'd1;
        end else begin
            instr_count <= instr_count;
        end
    end
`endif

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed, table-driven bench for the multi-cycle control unit (MEM_LAT=2, DEBOUNCE_CYCLES=4).
module tb_unidade_controle_multiciclo;
    import uc_pkg::*;

    localparam int TB_MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  op_in;
    logic        btn;
    logic        pc_write, ir_write, desv, we, io, rw, ula, rjr, rjl, halt;
    logic [1:0]  wd;
    logic [5:0]  modo;
    logic [2:0]  estado;
`ifdef INSTR_COUNT_EN
    logic [31:0] instr_count;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    unidade_controle_multiciclo #(
        .OPCODE_W(6), .MEM_LAT(TB_MEM_LAT), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock                    (clk),
        .reset                    (rst_n),
        .Modo_Funcao_UC_Instrucao (op_in),
        .clock_botao              (btn),
        .pc_write                 (pc_write),
        .ir_write                 (ir_write),
        .Seletor_Desvio_UC        (desv),
        .we_UC                    (we),
        .IO_UC                    (io),
        .Reg_Write_UC             (rw),
        .Seletor_ULA_UC           (ula),
        .Seletor_regJr_UC         (rjr),
        .Reg_Write_Jr_UC          (rjl),
        .halt                     (halt),
        .Seletor_W_Data_UC        (wd),
        .Modo_Funcao_UC           (modo),
        .estado                   (estado)
`ifdef INSTR_COUNT_EN
        ,
        .instr_count              (instr_count)
`endif
    );

    typedef struct {
        string      name;
        logic [5:0] op;
        logic       ula, desv, mem, store, rw, io, jl, jr;
        logic [1:0] wd;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [14:0] pk(input logic [2:0] e, input logic p, i, d, w, o, r, u, j, l, h,
                                       input logic [1:0] s);
        return {e, p, i, d, w, o, r, u, j, l, h, s};
    endfunction

    function automatic logic [14:0] got();
        return {estado, pc_write, ir_write, desv, we, io, rw, ula, rjr, rjl, halt, wd};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        op_in = v.op;
        tick(); chk({v.name, "_decode"}, got(), pk(3'd1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00));
        tick(); chk({v.name, "_exec"}, got(), pk(3'd2, 0, 0, v.desv, 0, 0, 0, v.ula, 1, 0, 0, 2'b00));
        if (v.mem) begin
            for (int k = 0; k <= TB_MEM_LAT; k++) begin
                tick();
                chk({v.name, "_mem"}, got(),
                    pk(3'd3, 0, 0, 0, v.store && (k == TB_MEM_LAT), 0, 0, 0, 1, 0, 0, 2'b00));
            end
        end
        tick(); chk({v.name, "_wb"}, got(), pk(3'd4, 1, 0, 0, 0, v.io, v.rw, 0, !v.jr, v.jl, 0, v.wd));
        chk({v.name, "_opcode"}, {26'd0, modo}, {26'd0, v.op});
        tick(); chk({v.name, "_fetch"}, got(), pk(3'd0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00));
    endtask

    task automatic wait_wb(input string name, input int exp_lat);
        int n;
        n = 0;
        while (estado != 3'd4 && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_latency"}, n, exp_lat);
        chk({name, "_wb"}, got(), pk(3'd4, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b11));
    endtask

    initial begin
        logic ok;
        //            name      op         ula desv mem st rw io jl jr wd
        vecs[0]  = '{"add",    OP_ADD,    0, 0, 0, 0, 1, 0, 0, 0, 2'b00};
        vecs[1]  = '{"subi",   OP_SUBI,   1, 0, 0, 0, 1, 0, 0, 0, 2'b00};
        vecs[2]  = '{"beq",    OP_BEQ,    0, 1, 0, 0, 0, 0, 0, 0, 2'b00};
        vecs[3]  = '{"load",   OP_LOAD,   0, 0, 1, 0, 1, 0, 0, 0, 2'b01};
        vecs[4]  = '{"store",  OP_STORE,  0, 0, 1, 1, 0, 0, 0, 0, 2'b00};
        vecs[5]  = '{"out",    OP_OUT,    0, 0, 0, 0, 0, 1, 0, 0, 2'b11};
        vecs[6]  = '{"jumpjl", OP_JUMPJL, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00};
        vecs[7]  = '{"jumpjr", OP_JUMPJR, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00};
        vecs[8]  = '{"loadim", OP_LOADIM, 1, 0, 0, 0, 1, 0, 0, 0, 2'b00};
        vecs[9]  = '{"unk",    6'b100000, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00};
        vecs[10] = '{"shl",    OP_SHL,    0, 0, 0, 0, 1, 0, 0, 0, 2'b00};
        vecs[11] = '{"bgr",    OP_BGR,    0, 1, 0, 0, 0, 0, 0, 0, 2'b00};

        rst_n = 1'b0;
        btn   = 1'b0;
        op_in = OP_ADD;
        #22;
        chk("reset_outputs", got(), pk(3'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00));
        chk("reset_opcode", {26'd0, modo}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // IN: 3-cycle glitch rejected, then a clean press exits
        op_in = OP_IN;
        tick(); chk("in_decode", got(), pk(3'd1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00));
        tick(); chk("in_wait", got(), pk(3'd5, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 2'b00));
        btn = 1'b1;
        repeat (3) tick();
        btn = 1'b0;
        repeat (8) tick();
        chk("in_glitch_ignored", got(), pk(3'd5, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 2'b00));
        btn = 1'b1;
        wait_wb("in_press", 7);
        btn = 1'b0;
        tick(); chk("in_fetch", got(), pk(3'd0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00));

        // IN entered with the button already held high
        run_vec(vecs[0]);
        run_vec(vecs[0]);
        btn = 1'b1;
        run_vec(vecs[0]);
        op_in = OP_IN;
        tick(); tick();
        chk("held_wait", got(), pk(3'd5, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 2'b00));
        repeat (15) tick();
        chk("held_ignored", got(), pk(3'd5, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 2'b00));
        btn = 1'b0;
        repeat (10) tick();
        chk("release_no_exit", got(), pk(3'd5, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 2'b00));
        btn = 1'b1;
        wait_wb("repress", 7);
        btn = 1'b0;
        tick();

        // Reset in the last MEM cycle of a STORE
        op_in = OP_STORE;
        tick(); tick();
        repeat (TB_MEM_LAT + 1) tick();
        chk("store_last_mem", got(), pk(3'd3, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 2'b00));
        #2 rst_n = 1'b0;
        #1 chk("reset_mid_store", got(), pk(3'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00));
        #3 rst_n = 1'b1;
        run_vec(vecs[4]);
        for (int i = 0; i < 4; i++) run_vec(vecs[i]);
`ifdef INSTR_COUNT_EN
        chk("instr_count_5", instr_count, 32'd5);
`endif

        // HLT parks the unit for good
        op_in = OP_HLT;
        tick(); chk("hlt_decode", got(), pk(3'd1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00));
        tick(); chk("halted", got(), pk(3'd6, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00));
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) btn = 1'b1;
            tick();
            if (estado != 3'd6 || halt != 1'b1 || pc_write != 1'b0) ok = 1'b0;
        end
        chk("halted_100", {31'd0, ok}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/unidade_controle_multiciclo.md
Name: unidade_controle_multiciclo

Overview:
- Parametrised multi-cycle successor to the single-cycle combinational control unit.
- Sequences every instruction through FETCH/DECODE/EXEC/MEM/WB states and drives registered datapath strobes.
- Replaces the combinational IN "halt while button low" hack with a synchronised, debounced button handshake.
- Sits between the instruction register and the datapath; the PC and IR are now written only on strobes from this block.

Parameters:
- OPCODE_W, 6, opcode width; opcode values are the package constants, zero-extended if OPCODE_W > 6.
- MEM_LAT, 1, extra wait cycles in MEM for LOAD/STORE (0..15).
- DEBOUNCE_CYCLES, 4, synchronised button level must be stable this many cycles before it is accepted (1..255).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Modo_Funcao_UC_Instrucao  in  OPCODE_W  opcode field from the IR.
- clock_botao  in  1  raw asynchronous input-confirm button, active high.
- pc_write, ir_write  out  1  PC update / IR load strobes.
- Seletor_Desvio_UC, we_UC, IO_UC, Reg_Write_UC, Seletor_ULA_UC, Seletor_regJr_UC, Reg_Write_Jr_UC, halt  out  1  datapath controls, same meaning as the previous unit.
- Seletor_W_Data_UC  out  2  write-data mux select.
- Modo_Funcao_UC  out  OPCODE_W  opcode latched in DECODE.
- estado  out  3  current state, for debug and display.

Behaviour:
- Reset (async assert, sync release): state FETCH; all strobes 0; Seletor_regJr_UC=1; Seletor_W_Data_UC=00; Modo_Funcao_UC=0; halt=0.
- All outputs are registered: they change only on a clock edge, as a function of the next state and the latched opcode.
- FETCH (1 cycle): ir_write=1 -> DECODE.
- DECODE: latch opcode.
  - HLT -> HALTED.
  - IN -> WAIT_IN.
  - Else -> EXEC.
- EXEC: Seletor_ULA_UC=1 for ADDI/SUBI/LOADIM; Seletor_Desvio_UC=1 for BEQ/BNE/BLE/BGR.
  - LOAD/STORE -> MEM.
  - Else -> WB.
- MEM: lasts MEM_LAT+1 cycles, counted by an internal counter. we_UC=1 only in the last MEM cycle for STORE. -> WB.
- WB (1 cycle): pc_write=1.
  - Reg_Write_UC=1 for ALU, imm, LOAD and IN ops.
  - Seletor_W_Data_UC: 01 for LOAD, 11 for IN/OUT, else 00.
  - IO_UC=1 for OUT.
  - Reg_Write_Jr_UC=1 for JUMPJL; Seletor_regJr_UC=0 for JUMPJR.
  - -> FETCH.
- Instruction latency: 4 cycles; LOAD/STORE 5+MEM_LAT; IN 4+wait.
- WAIT_IN: halt=1, IO_UC=1.
  - Leave only on a debounced rising edge of the button (2-flop sync, stable high DEBOUNCE_CYCLES cycles after a stable-low period) -> WB.
  - A button already held high on entry is ignored until it is released.
- HALTED: halt=1, terminal; only reset exits.
- Unknown opcode: NOP path (EXEC -> WB with only pc_write).
- Reset mid-instruction: the instruction is abandoned, no strobe glitch, restart at FETCH. Pending MEM or debounce counts are cleared.
- Button bounce shorter than DEBOUNCE_CYCLES: ignored.
- Simultaneous reset and button: reset wins.

Optional Feature:
- INSTR_COUNT_EN
  - Defined: adds output instr_count [31:0], which increments on every WB cycle, wraps at 2^32-1 -> 0, and resets to 0.
  - Undefined: the port and counter are absent.

Decomposition:
- Package uc_pkg:
  - Opcode localparams: ADD..SHL, ADDI, SUBI, BEQ..BGR, JUMP, JUMPJR, JUMPJL, IN, OUT, LOAD, STORE, LOADIM, HLT=6'b111111.
  - State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, WAIT_IN=5, HALTED=6.
  - W_DATA select constants.
- Sub-module botao_debounce (synchroniser, stability counter, rising-edge pulse), instantiated once.

Test Plan:
- ADD (000000) after reset -> estado 0,1,2,4,0; Reg_Write_UC=1 and pc_write=1 only in WB cycle 4.
- LOAD with MEM_LAT=2 -> 3 MEM cycles, Seletor_W_Data_UC=01 in WB; STORE -> we_UC=1 only in last MEM cycle.
- IN with button 3-cycle glitch (DEBOUNCE_CYCLES=4) -> stays WAIT_IN, halt=1; then clean press -> WB, Reg_Write_UC=1, halt=0.
- Button held high before IN decodes -> no exit until release and re-press.
- Reset asserted in MEM mid-STORE -> we_UC drops asynchronously, estado=FETCH; HLT -> HALTED persists 100 cycles.
- INSTR_COUNT_EN defined, 5 instructions run -> instr_count=5; preset near 0xFFFFFFFF -> wraps to 0.
